// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode/funct constants, control-field codes and the control output bundle.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_EX_R    = 5'd2,
    S_WB_R    = 5'd3,
    S_EX_ADDR = 5'd4,
    S_MEM_RD  = 5'd5,
    S_WB_LW   = 5'd6,
    S_MEM_WR  = 5'd7,
    S_EX_BR   = 5'd8,
    S_EX_J    = 5'd9,
    S_EX_JAL  = 5'd10,
    S_EX_JR   = 5'd11,
    S_EX_I    = 5'd12,
    S_WB_I    = 5'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] MR_ALUOUT = 2'd0, MR_MDR = 2'd1, MR_PC = 2'd2;
  localparam logic [1:0] SB_B = 2'd0, SB_FOUR = 2'd1, SB_IMM = 2'd2, SB_IMM_SH = 2'd3;
  localparam logic [1:0] PS_ALU = 2'd0, PS_ALUOUT = 2'd1, PS_JUMP = 2'd2, PS_REG_A = 2'd3;
  localparam logic [1:0] AO_ADD = 2'd0, AO_SUB = 2'd1, AO_FUNCT = 2'd2, AO_IMM = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       br_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       illegal;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational next-state decode for mc_ctrl_fsm. mem_go is the memory
// handshake already resolved by the top (constant 1 when waits are disabled).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_go,
  output state_e     next_state
);

  // next-state selection; anything unrecognised falls back to fetch
  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF:      next_state = mem_go ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_RTYPE:                         next_state = (funct == FN_JR) ? S_EX_JR : S_EX_R;
          OP_LW, OP_SW:                     next_state = S_EX_ADDR;
          OP_BEQ, OP_BNE:                   next_state = S_EX_BR;
          OP_J:                             next_state = S_EX_J;
          OP_JAL:                           next_state = S_EX_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = S_EX_I;
          default:                          next_state = S_IF;
        endcase
      end
      S_EX_R:    next_state = S_WB_R;
      S_EX_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  next_state = mem_go ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:  next_state = mem_go ? S_IF : S_MEM_WR;
      S_EX_I:    next_state = S_WB_I;
      default:   next_state = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for a multi-cycle MIPS datapath. Define MC_CTRL_MEM_WAIT_EN
// to make IF/MEM_RD/MEM_WR stall on mem_ready; by default mem_ready is ignored.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       br_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       illegal,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [4:0] state
);

  state_e state_r;
  state_e next_s;
  ctrl_t  ctrl_s;
  logic   mem_go_s;
  logic   unused_s;

  // branch resolution uses zero in the datapath, not here
`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_go_s = mem_ready;
  assign unused_s = zero;
`else
  assign mem_go_s = 1'b1;
  assign unused_s = ^{zero, mem_ready};
`endif

  mc_ctrl_decode u_decode (
    .state      (state_r),
    .opcode     (opcode),
    .funct      (funct),
    .mem_go     (mem_go_s),
    .next_state (next_s)
  );

  // state register with synchronous reset to fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_s;
    end
  end

  // output decode of the state register, forced quiet while reset is held
  always_comb begin
    ctrl_s = '0;
    state  = 5'd0;
    if (rst) begin
      ctrl_s = '0;
    end else begin
      state = state_r;
      case (state_r)
        S_IF: begin
          ctrl_s.mem_read  = 1'b1;
          ctrl_s.ir_write  = mem_go_s;
          ctrl_s.pc_write  = mem_go_s;
          ctrl_s.alu_src_b = SB_FOUR;
          ctrl_s.pc_source = PS_ALU;
        end
        S_ID: begin
          ctrl_s.alu_src_b = SB_IMM_SH;
          ctrl_s.alu_op    = AO_ADD;
          ctrl_s.illegal   = ~op_legal(opcode);
        end
        S_EX_R: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SB_B;
          ctrl_s.alu_op    = AO_FUNCT;
        end
        S_WB_R: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = RD_RD;
          ctrl_s.mem_to_reg = MR_ALUOUT;
        end
        S_EX_ADDR, S_EX_I: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SB_IMM;
          ctrl_s.alu_op    = (state_r == S_EX_I && opcode != OP_ADDI) ? AO_IMM : AO_ADD;
        end
        S_MEM_RD: begin
          ctrl_s.mem_read = 1'b1;
          ctrl_s.i_or_d   = 1'b1;
        end
        S_WB_LW: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = RD_RT;
          ctrl_s.mem_to_reg = MR_MDR;
        end
        S_MEM_WR: begin
          ctrl_s.mem_write = 1'b1;
          ctrl_s.i_or_d    = 1'b1;
        end
        S_EX_BR: begin
          ctrl_s.alu_src_a     = 1'b1;
          ctrl_s.alu_src_b     = SB_B;
          ctrl_s.alu_op        = AO_SUB;
          ctrl_s.pc_write_cond = 1'b1;
          ctrl_s.pc_source     = PS_ALUOUT;
          ctrl_s.br_ne         = (opcode == OP_BNE);
        end
        S_EX_J: begin
          ctrl_s.pc_write  = 1'b1;
          ctrl_s.pc_source = PS_JUMP;
        end
        S_EX_JAL: begin
          ctrl_s.pc_write   = 1'b1;
          ctrl_s.pc_source  = PS_JUMP;
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = RD_RA;
          ctrl_s.mem_to_reg = MR_PC;
        end
        S_EX_JR: begin
          ctrl_s.pc_write  = 1'b1;
          ctrl_s.pc_source = PS_REG_A;
        end
        S_WB_I: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = RD_RT;
          ctrl_s.mem_to_reg = MR_ALUOUT;
        end
        default: ctrl_s = '0;
      endcase
    end
  end

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign br_ne         = ctrl_s.br_ne;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign ir_write      = ctrl_s.ir_write;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign illegal       = ctrl_s.illegal;
  assign reg_dst       = ctrl_s.reg_dst;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign pc_source     = ctrl_s.pc_source;
  assign alu_op        = ctrl_s.alu_op;

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL provide ports as listed: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-004 SHALL provide: mem_ready  in  1  memory done; used only when MEM_WAIT_EN is defined.
REQ-005 SHALL provide 1-bit outputs: pc_write, pc_write_cond, br_ne, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal.
REQ-006 SHALL provide 2-bit outputs: reg_dst (0 rt, 1 rd, 2 $31), mem_to_reg (0 ALUOut, 1 MDR, 2 PC), alu_src_b (0 B, 1 const 4, 2 sign-ext imm, 3 imm<<2), pc_source (0 ALU, 1 ALUOut, 2 jump target, 3 reg A), alu_op (0 add, 1 sub, 2 funct, 3 imm-op).
REQ-007 SHALL provide: state  out  5  current state code, for debug.

Function
REQ-008 SHALL be a Moore FSM; every output SHALL be a pure decode of the state register.
REQ-009 SHALL implement states IF, ID, EX_R, WB_R, EX_ADDR, MEM_RD, WB_LW, MEM_WR, EX_BR, EX_J, EX_JAL, EX_JR, EX_I, WB_I.
REQ-010 IF: mem_read=1, ir_write=1, alu_src_b=1, pc_write=1, pc_source=0, i_or_d=0; next state ID.
REQ-011 ID: alu_src_b=3, alu_op=0 (branch target into ALUOut); decode opcode/funct.
REQ-012 Decode from ID: R-type (op 0x00, funct other than 0x08) -> EX_R; jr (op 0x00, funct 0x08) -> EX_JR; lw 0x23 / sw 0x2B -> EX_ADDR; beq 0x04 / bne 0x05 -> EX_BR; j 0x02 -> EX_J; jal 0x03 -> EX_JAL; addi 0x08 / slti 0x0A / andi 0x0C / ori 0x0D -> EX_I.
REQ-013 Any other opcode in ID: assert illegal for exactly one cycle (the ID cycle), no write enables, next state IF.
REQ-014 EX_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> WB_R. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> IF.
REQ-015 EX_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0 -> MEM_RD (lw) or MEM_WR (sw).
REQ-016 MEM_RD: mem_read=1, i_or_d=1 -> WB_LW. WB_LW: reg_write=1, reg_dst=0, mem_to_reg=1 -> IF. MEM_WR: mem_write=1, i_or_d=1 -> IF.
REQ-017 EX_BR: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, br_ne=1 for bne only -> IF.
REQ-018 EX_J: pc_write=1, pc_source=2 -> IF. EX_JAL: additionally reg_write=1, reg_dst=2, mem_to_reg=2 -> IF. EX_JR: pc_write=1, pc_source=3 -> IF.
REQ-019 EX_I: alu_src_a=1, alu_src_b=2, alu_op=0 for addi else 3 -> WB_I. WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> IF.
REQ-020 Latency, without MEM_WAIT_EN: j/jal/jr/beq/bne 3 cycles; R-type, sw, imm-ops 4 cycles; lw 5 cycles.
REQ-021 Unlisted outputs in any state SHALL be 0. An unencoded state value SHALL drive all outputs to 0 and return to IF.

Reset
REQ-022 rst=1 at a rising edge SHALL load state IF, including mid-instruction.
REQ-023 While rst=1, all outputs SHALL be forced to 0 (pc_write, reg_write, mem_write, ir_write included). The first cycle after rst falls SHALL be IF.

Configuration
REQ-024 Macro MC_CTRL_MEM_WAIT_EN: when defined, IF, MEM_RD and MEM_WR SHALL hold state and outputs while mem_ready=0 and advance on mem_ready=1.
REQ-025 While waiting in IF, pc_write and ir_write SHALL be 0 and are asserted only in the cycle with mem_ready=1.
REQ-026 When the macro is undefined, mem_ready SHALL be ignored and every memory state SHALL last one cycle.

Structure
REQ-027 Shared package mc_ctrl_pkg SHALL hold the state encoding typedef, the opcode/funct constants, and the reg_dst/mem_to_reg/alu_src_b/pc_source/alu_op code constants.
REQ-028 Sub-module mc_ctrl_decode SHALL be purely combinational, mapping (state, opcode, funct) to next state. Output decode SHALL remain in the top module.

Verification
REQ-029 Reset: assert rst mid-lw at MEM_RD -> next state IF; all outputs 0 while rst=1.
REQ-030 lw (op 0x23) -> states IF, ID, EX_ADDR, MEM_RD, WB_LW over 5 cycles; in WB_LW, reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-031 jal (op 0x03) -> 3 cycles; EX_JAL has reg_dst=2, mem_to_reg=2, pc_source=2, pc_write=1.
REQ-032 bne (op 0x05), zero=0 -> EX_BR with pc_write_cond=1, br_ne=1; beq -> br_ne=0.
REQ-033 opcode 0x3F -> illegal=1 in the ID cycle only, then IF, with no write enable asserted.
REQ-034 With MEM_WAIT_EN defined and mem_ready held low 3 cycles in MEM_WR -> mem_write held 4 cycles, then IF.
